// File: rtl/aes_sched_pkg.sv
// Shared types for the AES job scheduler.
//   sched_state_t : scheduler FSM states
//   job_t         : one queued job (channel, mode, text block)
// The channel field width is fixed here so that job_t, the FIFO word and the
// top-level channel ports all agree.
package aes_sched_pkg;

    localparam int AES_BLK_W    = 128;
    localparam int SCHED_NUM_CH = 4;
    localparam int SCHED_CH_W   = (SCHED_NUM_CH > 1) ? $clog2(SCHED_NUM_CH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        KWAIT,
        TLOAD,
        TWAIT,
        OUT
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_CH_W-1:0] ch;
        logic                  mode;
        logic [AES_BLK_W-1:0]  text;
    } job_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous show-ahead FIFO used as the scheduler job queue.
//   clk, rst     : clock, synchronous active-high reset (pointers only)
//   push, wdata  : write request and word; ignored when full unless popping
//   pop          : remove head word; ignored when empty
//   rdata        : current head word (valid while !empty)
//   full, empty  : occupancy flags
module aes_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/aes_job_sched.sv
// Multi-channel job scheduler in front of a single AES core.
//   key_wr/key_ch/key_data        : key table write port
//   in_valid/in_ready/in_ch/in_mode/in_text : job input stream
//   out_valid/out_ready/out_ch/out_text     : result stream
//   err_nokey, err_timeout        : one-cycle error pulses
//   busy                          : FSM active or jobs queued
//   core_*                        : ld/kld/done/kdone interface to the AES core
// Key expansion is skipped when the core already holds the key and mode of
// the next job. All core-facing and result outputs are registered.
module aes_job_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_CH      = SCHED_NUM_CH,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_W      = AES_BLK_W,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 64,
    localparam int CH_W       = SCHED_CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic [CH_W-1:0]   key_ch,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_text,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_text,
    output logic              err_nokey,
    output logic              err_timeout,
    output logic              busy,
    output logic              core_mode,
    output logic              core_ld,
    output logic              core_kld,
    output logic [KEY_W-1:0]  core_key,
    output logic [DATA_W-1:0] core_text_in,
    input  logic              core_kdone,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_text_out
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Key table
    logic [KEY_W-1:0]  key_q [NUM_CH];
    logic [NUM_CH-1:0] key_vld_q;

    always_ff @(posedge clk) begin
        if (key_wr) key_q[key_ch] <= key_data;
    end

    always_ff @(posedge clk) begin
        if (rst)         key_vld_q         <= '0;
        else if (key_wr) key_vld_q[key_ch] <= 1'b1;
    end

    // Job FIFO
    job_t job_in;
    job_t head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;

    sched_state_t     state_q;
    job_t             job_q;
    logic             loaded_vld_q;
    logic [CH_W-1:0]  loaded_ch_q;
    logic             loaded_mode_q;
    logic             stale_q;
    logic [TW-1:0]    tmo_q;
    logic             core_mode_q;
    logic             core_ld_q;
    logic             core_kld_q;
    logic [KEY_W-1:0] core_key_q;
    logic [DATA_W-1:0] core_text_in_q;
    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [DATA_W-1:0] out_text_q;
    logic             err_nokey_q;
    logic             err_timeout_q;
    logic             need_kld;
    logic             key_hit_loaded;
    logic             tmo_hit;

    assign job_in    = '{ch: in_ch, mode: in_mode, text: in_text};
    // in_ready is held low during reset so every output reads 0 while rst is high.
    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    aes_sched_fifo #(
        .WIDTH ($bits(job_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (job_in),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign need_kld       = !loaded_vld_q || (head.ch != loaded_ch_q) ||
                            (head.mode != loaded_mode_q);
    assign key_hit_loaded = key_wr && (key_ch == loaded_ch_q);
    assign tmo_hit        = (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            loaded_vld_q   <= 1'b0;
            loaded_ch_q    <= '0;
            loaded_mode_q  <= 1'b0;
            stale_q        <= 1'b0;
            tmo_q          <= '0;
            core_mode_q    <= 1'b0;
            core_ld_q      <= 1'b0;
            core_kld_q     <= 1'b0;
            core_key_q     <= '0;
            core_text_in_q <= '0;
            out_valid_q    <= 1'b0;
            out_ch_q       <= '0;
            out_text_q     <= '0;
            err_nokey_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            core_ld_q     <= 1'b0;
            core_kld_q    <= 1'b0;
            err_nokey_q   <= 1'b0;
            err_timeout_q <= 1'b0;

            // A rewrite of the key the core holds invalidates it; stale_q
            // stops a key expansion already under way from marking it valid.
            if (key_hit_loaded) begin
                loaded_vld_q <= 1'b0;
                stale_q      <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (!key_vld_q[head.ch]) begin
                            err_nokey_q <= 1'b1;
                        end else begin
                            job_q <= head;
                            if (need_kld) begin
                                state_q       <= KLOAD;
                                core_kld_q    <= 1'b1;
                                core_key_q    <= key_q[head.ch];
                                core_mode_q   <= head.mode;
                                loaded_ch_q   <= head.ch;
                                loaded_mode_q <= head.mode;
                                loaded_vld_q  <= 1'b0;
                                stale_q       <= key_wr && (key_ch == head.ch);
                            end else begin
                                state_q        <= TLOAD;
                                core_ld_q      <= 1'b1;
                                core_text_in_q <= head.text;
                                core_mode_q    <= head.mode;
                            end
                        end
                    end
                end
                KLOAD: begin
                    state_q <= KWAIT;
                    tmo_q   <= '0;
                end
                KWAIT: begin
                    if (core_kdone) begin
                        loaded_vld_q   <= !(stale_q || key_hit_loaded);
                        state_q        <= TLOAD;
                        core_ld_q      <= 1'b1;
                        core_text_in_q <= job_q.text;
                        core_mode_q    <= job_q.mode;
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        loaded_vld_q  <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                TLOAD: begin
                    state_q <= TWAIT;
                    tmo_q   <= '0;
                end
                TWAIT: begin
                    if (core_done) begin
                        out_text_q  <= core_text_out;
                        out_ch_q    <= job_q.ch;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        loaded_vld_q  <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE) || !fifo_empty;
    assign core_mode    = core_mode_q;
    assign core_ld      = core_ld_q;
    assign core_kld     = core_kld_q;
    assign core_key     = core_key_q;
    assign core_text_in = core_text_in_q;
    assign out_valid    = out_valid_q;
    assign out_ch       = out_ch_q;
    assign out_text     = out_text_q;
    assign err_nokey    = err_nokey_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_aes_job_sched.sv
module tb_aes_job_sched;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2  = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] K3  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] TA  = 128'h11111111222222223333333344444444;
    localparam logic [127:0] TB  = 128'hcafef00d000000010000000200000003;
    localparam logic [127:0] TC  = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] TD  = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    localparam logic [127:0] TE  = 128'h80000000000000000000000000000001;
    localparam logic [127:0] TF  = 128'h0badc0de0badc0de0badc0de0badc0de;
    localparam logic [127:0] TG  = 128'h13572468135724681357246813572468;
    localparam logic [127:0] TBP = 128'ha0000000000000000000000000000000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_wr = 1'b0;
    logic [1:0]   key_ch = '0;
    logic [127:0] key_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_ch = '0;
    logic         in_mode = 1'b0;
    logic [127:0] in_text = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_ch;
    logic [127:0] out_text;
    logic         err_nokey, err_timeout, busy;
    logic         core_mode, core_ld, core_kld;
    logic [127:0] core_key, core_text_in;
    logic         core_kdone = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_text_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_job_sched dut (
        .clk(clk), .rst(rst),
        .key_wr(key_wr), .key_ch(key_ch), .key_data(key_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_mode(in_mode), .in_text(in_text),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_text(out_text),
        .err_nokey(err_nokey), .err_timeout(err_timeout), .busy(busy),
        .core_mode(core_mode), .core_ld(core_ld), .core_kld(core_kld),
        .core_key(core_key), .core_text_in(core_text_in),
        .core_kdone(core_kdone), .core_done(core_done),
        .core_text_out(core_text_out)
    );

    // Stand-in AES core: the FIPS-197 vector is answered exactly, any other
    // block gets text ^ key, inverted for decrypt.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t,
                                             input logic m);
        if (k == K0 && t == PT0 && !m) return CT0;
        return (t ^ k) ^ {128{m}};
    endfunction

    logic [127:0] m_key = '0;
    logic [127:0] m_text = '0;
    logic         m_mode = 1'b0;
    int           kcnt = 0, dcnt = 0, kld_count = 0, ld_count = 0;
    bit           never_done = 1'b0;

    always @(posedge clk) begin
        core_kdone <= 1'b0;
        core_done  <= 1'b0;
        if (core_kld) begin
            m_key     <= core_key;
            kcnt      <= 3;
            kld_count <= kld_count + 1;
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) core_kdone <= 1'b1;
        end
        if (core_ld) begin
            m_text   <= core_text_in;
            m_mode   <= core_mode;
            dcnt     <= 4;
            ld_count <= ld_count + 1;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !never_done) core_done <= 1'b1;
        end
    end

    assign core_text_out = core_fn(m_key, m_text, m_mode);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic write_key(input logic [1:0] ch, input logic [127:0] k);
        key_wr = 1'b1; key_ch = ch; key_data = k;
        @(negedge clk);
        key_wr = 1'b0;
    endtask

    task automatic send_job(input logic [1:0] ch, input logic m, input logic [127:0] t);
        int n;
        n = 0;
        in_ch = ch; in_mode = m; in_text = t; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string name, input logic [1:0] ch, input logic [127:0] t);
        int n;
        n = 0;
        while (!out_valid && n < 150) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_ch"}, out_ch, ch);
        check({name, "_text"}, out_text, t);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_released"}, out_valid, 1'b0);
    endtask

    task automatic wait_ld();
        int n;
        n = 0;
        while (!core_ld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_ld", core_ld, 1'b1);
    endtask

    typedef struct {
        logic [1:0]   ch;
        logic         mode;
        logic [127:0] text;
        logic [1:0]   exp_ch;
        logic [127:0] exp_text;
        int           exp_kld;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, l0, n, cyc, cnt, ov;
        bit stable;
        logic [127:0] held;

        vecs[0] = '{2'd0, 1'b0, PT0, 2'd0, CT0, 1};
        vecs[1] = '{2'd0, 1'b0, TA,  2'd0, TA ^ K0, 0};
        vecs[2] = '{2'd1, 1'b0, TB,  2'd1, TB ^ K1, 1};
        vecs[3] = '{2'd0, 1'b0, TC,  2'd0, TC ^ K0, 1};
        vecs[4] = '{2'd1, 1'b0, TD,  2'd1, TD ^ K1, 1};
        vecs[5] = '{2'd1, 1'b1, TE,  2'd1, ~(TE ^ K1), 1};
        vecs[6] = '{2'd1, 1'b1, TA,  2'd1, ~(TA ^ K1), 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_core_ctl", {core_ld, core_kld, core_mode}, 3'b000);
        check("rst_err", {err_nokey, err_timeout}, 2'b00);
        check("rst_out_text", out_text, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        write_key(2'd0, K0);
        write_key(2'd1, K1);

        // Table-driven jobs, one at a time
        for (int i = 0; i < 7; i++) begin
            k0 = kld_count;
            l0 = ld_count;
            send_job(vecs[i].ch, vecs[i].mode, vecs[i].text);
            take_result($sformatf("vec%0d", i), vecs[i].exp_ch, vecs[i].exp_text);
            check($sformatf("vec%0d_kld", i), kld_count - k0, vecs[i].exp_kld);
            check($sformatf("vec%0d_ld", i), ld_count - l0, 1);
        end

        // Latency with the key already loaded (ch1 decrypt)
        check("lat_ready", in_ready, 1'b1);
        in_ch = 2'd1; in_mode = 1'b1; in_text = TC; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_pop_cycle_ld", core_ld, 1'b0);
        @(negedge clk);
        check("lat_ld_cycle", core_ld, 1'b1);
        n = 0;
        while (!core_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("lat_done_seen", core_done, 1'b1);
        check("lat_out_same_cycle", out_valid, 1'b0);
        @(negedge clk);
        check("lat_out_next_cycle", out_valid, 1'b1);
        take_result("lat", 2'd1, ~(TC ^ K1));

        // Two back-to-back ch0 jobs: one key load, two block loads
        k0 = kld_count;
        l0 = ld_count;
        in_ch = 2'd0; in_mode = 1'b0; in_text = TF; in_valid = 1'b1;
        check("b2b_ready0", in_ready, 1'b1);
        @(negedge clk);
        in_text = TG;
        check("b2b_ready1", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        take_result("b2b0", 2'd0, TF ^ K0);
        take_result("b2b1", 2'd0, TG ^ K0);
        check("b2b_kld", kld_count - k0, 1);
        check("b2b_ld", ld_count - l0, 2);

        // Job on a channel whose key was never written
        l0 = ld_count;
        cnt = 0;
        ov = 0;
        send_job(2'd2, 1'b0, TA);
        repeat (12) begin
            @(negedge clk);
            if (err_nokey) cnt++;
            if (out_valid) ov++;
        end
        check("nokey_pulses", cnt, 1);
        check("nokey_ld", ld_count - l0, 0);
        check("nokey_out", ov, 0);
        check("nokey_busy", busy, 1'b0);

        // Core never answers
        never_done = 1'b1;
        send_job(2'd0, 1'b0, TB);
        wait_ld();
        cyc = 0;
        while (!err_timeout && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_cycles", cyc, 65);
        check("tmo_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check("tmo_pulse_width", err_timeout, 1'b0);
        check("tmo_busy", busy, 1'b0);
        never_done = 1'b0;
        k0 = kld_count;
        send_job(2'd0, 1'b0, TD);
        take_result("tmo_next", 2'd0, TD ^ K0);
        check("tmo_reload_kld", kld_count - k0, 1);

        // Result held with out_ready low while five jobs are queued
        for (int i = 0; i < 5; i++) begin
            send_job(2'd0, 1'b0, TBP + 128'(i));
        end
        check("bp_full_in_ready", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = out_text;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_text !== held || out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_still_full", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            take_result($sformatf("bp%0d", i), 2'd0, (TBP + 128'(i)) ^ K0);
        end

        // Reset while waiting for core_done
        send_job(2'd0, 1'b0, TE);
        wait_ld();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_core_ctl", {core_ld, core_kld}, 2'b00);
        check("mrst_core_text", core_text_in, 128'd0);
        check("mrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        ov = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        check("mrst_late_done_ignored", ov, 0);
        check("mrst_idle", busy, 1'b0);

        // Keys are gone after reset
        cnt = 0;
        send_job(2'd0, 1'b0, TA);
        repeat (6) begin
            @(negedge clk);
            if (err_nokey) cnt++;
        end
        check("mrst_nokey", cnt, 1);

        // New key, then rewrite of the loaded channel forces a reload
        write_key(2'd0, K2);
        k0 = kld_count;
        send_job(2'd0, 1'b0, TF);
        take_result("k2", 2'd0, TF ^ K2);
        check("k2_kld", kld_count - k0, 1);
        write_key(2'd0, K3);
        k0 = kld_count;
        send_job(2'd0, 1'b0, TG);
        take_result("k3", 2'd0, TG ^ K3);
        check("k3_kld", kld_count - k0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
